gcd_requester: RTL and testbench

- Initiator side of the GCD engine's start/done protocol.
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Issues one engine transaction at a time, captures the engine result on done, and returns it on a valid/ready result stream.
- Sits between the host/test logic and the gcd engine; the engine's a_in/b_in/start/result/done connect directly to the eng_* ports.

---
 rtl/gcd_requester.sv | 109 ++++++++++
 tb/tb_gcd_requester.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_requester.sv
// gcd_requester: buffers operand pairs and drives the GCD engine's start/done handshake, one transaction at a time.
// Optional WAIT-state abort with res_err is enabled by defining GCD_TIMEOUT_EN.
module gcd_requester #(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 4,
   parameter int START_CYCLES = 4,
   parameter int TIMEOUT      = 1023
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   op_valid,
   output logic                   op_ready,
   input  logic [WIDTH-1:0]       op_a,
   input  logic [WIDTH-1:0]       op_b,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [WIDTH-1:0]       res_data,
   output logic                   res_err,
   output logic [WIDTH-1:0]       eng_a,
   output logic [WIDTH-1:0]       eng_b,
   output logic                   eng_start,
   input  logic [WIDTH-1:0]       eng_result,
   input  logic                   eng_done,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_level
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(START_CYCLES + TIMEOUT + 2);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2*WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [WIDTH-1:0] head_a, head_b;
   logic init_q, push, pop, bypass, done_cap, abort;
   assign {head_a, head_b} = mem[rd_ptr];
   // init_q keeps op_ready low until the first clock after reset release
   assign op_ready  = init_q && (fifo_level != (AW+1)'(DEPTH));
   assign push      = op_valid && op_ready;
   assign bypass    = pop && (head_a == '0 || head_b == '0);
   assign done_cap  = (state == WAIT) && eng_done;
   assign eng_start = (state == ISSUE);
   assign busy      = (state != IDLE);
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pop     = 1'b0;
      abort   = 1'b0;
      case (state)
         IDLE: begin
            pop = (fifo_level != '0) && (!res_valid || res_ready);
            if (pop && head_a != '0 && head_b != '0) begin
               state_n = ISSUE;
               cnt_n   = '0;
            end
         end
         ISSUE: begin
            state_n = (cnt == CW'(START_CYCLES - 1)) ? WAIT : ISSUE;
            cnt_n   = (cnt == CW'(START_CYCLES - 1)) ? '0 : cnt + 1'b1;
         end
         WAIT: begin
            if (eng_done) state_n = IDLE;
`ifdef GCD_TIMEOUT_EN
            cnt_n = cnt + 1'b1;
            if (!eng_done && cnt == CW'(TIMEOUT - 1)) begin
               state_n = IDLE;
               abort   = 1'b1;
            end
`endif
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         init_q     <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         eng_a      <= '0;
         eng_b      <= '0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         res_err    <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         init_q     <= 1'b1;
         wr_ptr     <= wr_ptr + AW'(push);
         rd_ptr     <= rd_ptr + AW'(pop);
         fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
         if (pop && !bypass) begin
            eng_a <= head_a;
            eng_b <= head_b;
         end
         // a new load takes priority over the consume, so a bypass can refill the slot in the same cycle
         if (bypass || done_cap || abort) begin
            res_valid <= 1'b1;
            res_data  <= bypass ? ((head_a == '0) ? head_b : head_a) : done_cap ? eng_result : '0;
            res_err   <= abort;
         end else if (res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end
   always_ff @(posedge clk) if (push) mem[wr_ptr] <= {op_a, op_b};
endmodule

// File: tb/tb_gcd_requester.sv
// tb_gcd_requester: randomized self-checking bench for gcd_requester with a behavioural engine model.
`timescale 1ns/1ps
module tb_gcd_requester;
   localparam int W = 32, D = 4, SC = 4, TO = 20;
   logic clk = 0, reset_n = 0;
   logic op_valid = 0, res_ready = 0, eng_done = 0;
   logic [W-1:0] op_a = 0, op_b = 0, eng_result = 0;
   logic op_ready, res_valid, res_err, eng_start, busy;
   logic [W-1:0] res_data, eng_a, eng_b;
   logic [$clog2(D):0] fifo_level;
   int checks = 0, errors = 0;
   int mode = 0, starts = 0, last_len = 0, unstable = 0, busy_seen = 0, st_cnt = 0, dly = 0;
   bit pend = 0;
   logic [W-1:0] cap_a = 0, cap_b = 0;
   logic [W-1:0] exp_q[$];

   gcd_requester #(.WIDTH(W), .DEPTH(D), .START_CYCLES(SC), .TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
      .eng_a(eng_a), .eng_b(eng_b), .eng_start(eng_start), .eng_result(eng_result), .eng_done(eng_done),
      .busy(busy), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // engine model: mode 0 normal, 1 stale done during start, 2 never done
   always @(negedge clk) begin
      if (!reset_n) begin
         eng_done = 0;
         st_cnt = 0;
         pend = 0;
      end else begin
         eng_done = 0;
         if (busy) busy_seen++;
         if (eng_start) begin
            if (st_cnt == 0) begin
               cap_a = eng_a;
               cap_b = eng_b;
            end else if (eng_a !== cap_a || eng_b !== cap_b) unstable++;
            st_cnt++;
            if (mode == 1 && st_cnt == 2) begin
               eng_done = 1;
               eng_result = 32'hDEAD_BEEF;
            end
         end else begin
            if (st_cnt != 0) begin
               starts++;
               last_len = st_cnt;
               st_cnt = 0;
               pend = 1;
               dly = $urandom_range(0, 5);
            end
            if (pend) begin
               if (eng_a !== cap_a || eng_b !== cap_b) unstable++;
               if (dly == 0) begin
                  pend = 0;
                  if (mode != 2) begin
                     eng_done = 1;
                     eng_result = gcd(cap_a, cap_b);
                  end
               end else dly--;
            end
         end
      end
   end

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
      bit ok = 0;
      op_valid = 1;
      op_a = a;
      op_b = b;
      for (int i = 0; i < 500 && !ok; i++) begin
         ok = (op_ready === 1'b1);
         @(negedge clk);
      end
      op_valid = 0;
      if (ok) exp_q.push_back(gcd(a, b));
      else begin
         checks++;
         errors++;
         $display("FAIL push_timeout a=%0d b=%0d never accepted", a, b);
      end
   endtask

   task automatic get_result(output logic [W-1:0] d, output logic e, output bit ok);
      ok = 0;
      d = 0;
      e = 0;
      res_ready = 1;
      for (int i = 0; i < 500 && !ok; i++) begin
         if (res_valid === 1'b1) begin
            d = res_data;
            e = res_err;
            ok = 1;
         end
         @(negedge clk);
      end
      res_ready = 0;
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if ({op_ready, res_valid, res_data, res_err, eng_a, eng_b, eng_start, busy, fifo_level} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got ready=%b valid=%b start=%b busy=%b level=%0d, required all 0", op_ready, res_valid, eng_start, busy, fifo_level);
      end
      repeat (2) @(negedge clk);
      reset_n = 1;
      #1;
      checks++;
      if (op_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_early got %b required 0", op_ready);
      end
      @(negedge clk);
      checks++;
      if (op_ready !== 1'b1 || fifo_level !== 0) begin
         errors++;
         $display("FAIL reset_release got ready=%b level=%0d required 1/0", op_ready, fifo_level);
      end
   endtask

   task automatic test_basic;
      logic [W-1:0] d, exp;
      logic e;
      bit ok;
      int s0 = starts;
      push(48, 18);
      @(negedge clk);
      checks++;
      if (eng_start !== 1'b1) begin
         errors++;
         $display("FAIL basic_start_latency got eng_start=%b required 1", eng_start);
      end
      get_result(d, e, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || d !== 6 || exp !== 6 || e !== 1'b0) begin
         errors++;
         $display("FAIL basic_result got %0d err=%b ok=%b required 6 err=0", d, e, ok);
      end
      checks++;
      if (starts != s0 + 1 || last_len != SC || cap_a !== 48 || cap_b !== 18 || unstable != 0) begin
         errors++;
         $display("FAIL basic_engine got starts=%0d len=%0d a=%0d b=%0d unstable=%0d required %0d/%0d/48/18/0", starts - s0, last_len, cap_a, cap_b, unstable, 1, SC);
      end
   endtask

   task automatic test_bypass;
      logic [W-1:0] d, exp;
      logic e;
      bit ok;
      int s0 = starts;
      logic [W-1:0] av[2] = '{0, 9};
      logic [W-1:0] bv[2] = '{7, 0};
      busy_seen = 0;
      for (int k = 0; k < 2; k++) begin
         push(av[k], bv[k]);
         @(negedge clk);
         exp = exp_q.pop_front();
         checks++;
         if (res_valid !== 1'b1 || res_data !== exp) begin
            errors++;
            $display("FAIL bypass_latency[%0d] got valid=%b data=%0d required 1/%0d", k, res_valid, res_data, exp);
         end
         get_result(d, e, ok);
         checks++;
         if (!ok || d !== exp || e !== 1'b0) begin
            errors++;
            $display("FAIL bypass_result[%0d] got %0d err=%b required %0d err=0", k, d, e, exp);
         end
      end
      checks++;
      if (starts != s0 || busy_seen != 0) begin
         errors++;
         $display("FAIL bypass_no_engine got starts=%0d busy_cycles=%0d required 0/0", starts - s0, busy_seen);
      end
   endtask

   task automatic test_stale_done;
      logic [W-1:0] d;
      logic e;
      bit ok;
      mode = 1;
      push(48, 36);
      get_result(d, e, ok);
      void'(exp_q.pop_front());
      checks++;
      if (!ok || d !== 12 || e !== 1'b0) begin
         errors++;
         $display("FAIL stale_done got %0d err=%b required 12 err=0", d, e);
      end
      mode = 0;
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] d, exp;
      logic e;
      bit ok;
      res_ready = 0;
      fork
         for (int k = 0; k < 6; k++) push($urandom_range(1, 5000), $urandom_range(1, 5000));
         begin
            repeat (60) @(negedge clk);
            checks++;
            if (op_ready !== 1'b0 || fifo_level !== D || res_valid !== 1'b1) begin
               errors++;
               $display("FAIL b2b_full got ready=%b level=%0d valid=%b required 0/%0d/1", op_ready, fifo_level, res_valid, D);
            end
            for (int k = 0; k < 6; k++) begin
               get_result(d, e, ok);
               exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
               checks++;
               if (!ok || d !== exp || e !== 1'b0) begin
                  errors++;
                  $display("FAIL b2b_result[%0d] got %0d err=%b required %0d", k, d, e, exp);
               end
            end
         end
      join
   endtask

   task automatic test_random;
      logic [W-1:0] d, exp;
      logic e;
      bit ok;
      fork
         for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 3000), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 3000));
         end
         for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            get_result(d, e, ok);
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            checks++;
            if (!ok || d !== exp || e !== 1'b0) begin
               errors++;
               $display("FAIL random[%0d] got %0d err=%b required %0d", k, d, e, exp);
            end
         end
      join
   endtask

`ifdef GCD_TIMEOUT_EN
   task automatic test_timeout;
      logic [W-1:0] d;
      logic e;
      bit ok;
      int n = 0;
      mode = 2;
      push(5, 3);
      for (int i = 0; i < 50 && !(busy === 1'b1 && eng_start === 1'b0); i++) @(negedge clk);
      while (res_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != TO || res_data !== 0 || res_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_abort got cycles=%0d data=%0d err=%b required %0d/0/1", n, res_data, res_err, TO);
      end
      get_result(d, e, ok);
      exp_q.delete();
      mode = 0;
      push(12, 8);
      get_result(d, e, ok);
      void'(exp_q.pop_front());
      checks++;
      if (!ok || d !== 4 || e !== 1'b0) begin
         errors++;
         $display("FAIL timeout_recover got %0d err=%b required 4 err=0", d, e);
      end
   endtask
`endif

   task automatic test_reset_mid;
      int s0, seen = 0;
      mode = 2;
      res_ready = 0;
      push(35, 14);
      push(8, 6);
      push(0, 5);
      for (int i = 0; i < 50 && !(busy === 1'b1 && eng_start === 1'b0); i++) @(negedge clk);
      checks++;
      if (fifo_level !== 2 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_setup got level=%0d busy=%b required 2/1", fifo_level, busy);
      end
      #2 reset_n = 0;
      #1;
      checks++;
      if ({op_ready, res_valid, res_data, res_err, eng_a, eng_b, eng_start, busy, fifo_level} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs got ready=%b start=%b busy=%b level=%0d required all 0", op_ready, eng_start, busy, fifo_level);
      end
      @(negedge clk);
      reset_n = 1;
      exp_q.delete();
      mode = 0;
      s0 = starts;
      @(negedge clk);
      checks++;
      if (op_ready !== 1'b1 || fifo_level !== 0) begin
         errors++;
         $display("FAIL mid_release got ready=%b level=%0d required 1/0", op_ready, fifo_level);
      end
      res_ready = 1;
      repeat (20) begin
         if (res_valid === 1'b1 || eng_start === 1'b1) seen++;
         @(negedge clk);
      end
      res_ready = 0;
      checks++;
      if (seen != 0 || starts != s0) begin
         errors++;
         $display("FAIL mid_no_result got activity=%0d starts=%0d required 0/0", seen, starts - s0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bypass();
      test_stale_done();
      test_back_to_back();
      test_random();
`ifdef GCD_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete in time");
      $fatal(1);
   end
endmodule
